// File: rtl/mutex_rr_arbiter.sv
// Round-robin mutex arbiter with bounded hold time and forced-release lockout.
//
// One shared resource is owned by at most one requester at a time. Ownership
// persists across cycles until the owner releases, drops its request, or holds
// the grant for MAX_HOLD consecutive cycles. A timed-out owner is locked out
// until it drops its request. Every change of owner passes through a one-cycle
// dead gap with no grant.
//
// Parameters:
//   N_REQ    number of requesters (2..16)
//   MAX_HOLD maximum consecutive grant cycles per owner; 0 disables the timeout
//   CNT_W    hold counter width
//   ID_W     owner index width
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   request     per-requester lock request (level)
//   release_req per-requester release pulse, only the owner's bit counts
//               (`release` is a reserved word)
//   granted     registered one-hot grant, zero when unowned
//   owner_id    index of current owner, zero when unowned
//   busy        high whenever any grant is active
//   timeout     one-cycle pulse after a forced release
//   locked_out  registered per-requester lockout flags

module mutex_rr_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 64,
  parameter int unsigned CNT_W    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1),
  parameter int unsigned ID_W     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] request,
  input  logic [N_REQ-1:0] release_req,
  output logic [N_REQ-1:0] granted,
  output logic [ID_W-1:0]  owner_id,
  output logic             busy,
  output logic             timeout,
  output logic [N_REQ-1:0] locked_out
);

  localparam bit               HoldEn  = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HoldMax = CNT_W'(MAX_HOLD);
  localparam logic [ID_W:0]    NumReq  = (ID_W + 1)'(N_REQ);

  typedef enum logic [1:0] {
    StIdle,
    StOwned,
    StGap
  } state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] granted_q, granted_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic             timeout_q, timeout_d;
  logic [N_REQ-1:0] locked_q, locked_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first eligible index starting at rr_q, wrapping at N_REQ.
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0] eligible;
  logic             arb_found;
  logic [ID_W-1:0]  arb_winner;
  logic [ID_W:0]    scan_idx;
  logic [ID_W:0]    winner_inc;
  logic [ID_W-1:0]  rr_after_win;
  logic [N_REQ-1:0] winner_onehot;

  assign eligible = request & ~locked_q;

  always_comb begin
    arb_found  = 1'b0;
    arb_winner = '0;
    scan_idx   = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      // Extra index bit absorbs rr_q + off before the wrap.
      scan_idx = {1'b0, rr_q} + (ID_W + 1)'(off);
      if (scan_idx >= NumReq) begin
        scan_idx = scan_idx - NumReq;
      end
      if (!arb_found && eligible[scan_idx[ID_W-1:0]]) begin
        arb_found  = 1'b1;
        arb_winner = scan_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    winner_inc   = {1'b0, arb_winner} + (ID_W + 1)'(1);
    rr_after_win = (winner_inc == NumReq) ? '0 : winner_inc[ID_W-1:0];
  end

  always_comb begin
    winner_onehot             = '0;
    winner_onehot[arb_winner] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Owner release conditions.
  // ---------------------------------------------------------------------------
  logic owner_rel;
  logic owner_forced;

  assign owner_rel    = release_req[owner_q] | ~request[owner_q];
  assign owner_forced = HoldEn && (hold_q == HoldMax);

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    granted_d = granted_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    rr_d      = rr_q;
    hold_d    = hold_q;
    // A lockout clears as soon as its requester lets go of the request.
    locked_d  = locked_q & request;

    unique case (state_q)
      StIdle, StGap: begin
        if (arb_found) begin
          state_d   = StOwned;
          granted_d = winner_onehot;
          owner_d   = arb_winner;
          rr_d      = rr_after_win;
          hold_d    = HoldEn ? CNT_W'(1) : '0;
        end else begin
          state_d   = StIdle;
          granted_d = '0;
          owner_d   = '0;
          hold_d    = '0;
        end
      end

      StOwned: begin
        if (owner_rel) begin
          // Normal release takes priority over a simultaneous timeout.
          state_d   = StGap;
          granted_d = '0;
          owner_d   = '0;
          hold_d    = '0;
        end else if (owner_forced) begin
          state_d           = StGap;
          granted_d         = '0;
          owner_d           = '0;
          hold_d            = '0;
          timeout_d         = 1'b1;
          // Setting the lockout wins over a same-edge clear.
          locked_d[owner_q] = 1'b1;
        end else if (HoldEn && (hold_q != HoldMax)) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = StIdle;
        granted_d = '0;
        owner_d   = '0;
        hold_d    = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers; synchronous reset overrides everything.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      granted_q <= '0;
      owner_q   <= '0;
      timeout_q <= 1'b0;
      locked_q  <= '0;
      rr_q      <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      granted_q <= granted_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
      locked_q  <= locked_d;
      rr_q      <= rr_d;
      hold_q    <= hold_d;
    end
  end

  assign granted    = granted_q;
  assign owner_id   = owner_q;
  assign busy       = |granted_q;
  assign timeout    = timeout_q;
  assign locked_out = locked_q;

  // Grant is never shared.
  a_grant_onehot0 : assert property (@(posedge clk) $onehot0(granted_q));

endmodule
